// File: rtl/dac_player_pkg.sv
// Shared constants and types for the DAC stream player: sample width,
// idle output code, rate-divider width and the byte-assembler states.
package dac_player_pkg;

  localparam int          DATA_W   = 16;
  localparam logic [15:0] MIDSCALE = 16'h8000;
  localparam int          RATE_W   = 8;

  typedef enum logic {
    LO_WAIT = 1'b0,
    HI_WAIT = 1'b1
  } asm_state_e;

endpackage

// File: rtl/dac_stream_player_fifo.sv
// Synchronous sample FIFO (module sync_fifo). A pop on an empty FIFO is
// ignored; a push on a full FIFO is accepted only when a pop frees a slot.
module sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DATA_W-1:0]        wdata_i,
  output logic [DATA_W-1:0]        rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              do_push, do_pop;

  // Pop is evaluated first so a full FIFO can accept a push in the same cycle.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != FULL_CNT) || do_pop);
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/dac_stream_player.sv
// Byte-pair assembler, sample FIFO and rate-ticked DAC output register.
// Define DAC_PLAYER_HOLD_LAST_EN to hold the last sample on underrun.
module dac_stream_player
  import dac_player_pkg::*;
#(
  parameter int                DEPTH    = 8,
  parameter int                DATA_W   = dac_player_pkg::DATA_W,
  parameter logic [DATA_W-1:0] MIDSCALE = dac_player_pkg::MIDSCALE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        i_byte,
  input  logic              i_byte_valid,
  input  logic              i_sync,
  input  logic              i_enable,
  input  logic [RATE_W-1:0] i_rate_div,
  input  logic              i_clear,
  output logic [DATA_W-1:0] o_digital,
  output logic              o_sample_strobe,
  output logic              o_fifo_full,
  output logic              o_fifo_empty,
  output logic              o_overflow,
  output logic              o_underrun
);

  localparam int CW = $clog2(DEPTH);
  localparam logic [CW:0] FULL_CNT = (CW+1)'(DEPTH);

  asm_state_e        state_q, state_d;
  logic [7:0]        lo_q, lo_d;
  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] dig_q, dig_d;
  logic              strobe_q, strobe_d;
  logic              ovf_q, ovf_d;
  logic              und_q, und_d;

  logic              push_req, pop_req, tick, ovf_set, und_set;
  logic [DATA_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;
  logic [CW:0]       fifo_count;

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_req),
    .pop_i   (pop_req),
    .wdata_i ({i_byte, lo_q}),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d  = state_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    dig_d    = dig_q;
    strobe_d = 1'b0;
    push_req = 1'b0;
    pop_req  = 1'b0;
    tick     = 1'b0;
    und_set  = 1'b0;

    // A sync arriving with a byte realigns onto that byte as the new low half.
    if (i_byte_valid) begin
      if (i_sync || (state_q == LO_WAIT)) begin
        lo_d    = i_byte;
        state_d = HI_WAIT;
      end else begin
        push_req = 1'b1;
        state_d  = LO_WAIT;
      end
    end else if (i_sync) begin
      state_d = LO_WAIT;
    end

    if (!i_enable) begin
      cnt_d = '0;
    end else if (cnt_q >= i_rate_div) begin
      tick  = 1'b1;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (tick) begin
      if (!fifo_empty) begin
        pop_req  = 1'b1;
        dig_d    = fifo_rdata;
        strobe_d = 1'b1;
      end else begin
        und_set = 1'b1;
`ifdef DAC_PLAYER_HOLD_LAST_EN
        dig_d = dig_q;
`else
        dig_d = MIDSCALE;
`endif
      end
    end

    ovf_set = push_req && (fifo_count == FULL_CNT) && !pop_req;
    ovf_d   = ovf_set || (ovf_q && !i_clear);
    und_d   = und_set || (und_q && !i_clear);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= LO_WAIT;
      lo_q     <= '0;
      cnt_q    <= '0;
      dig_q    <= MIDSCALE;
      strobe_q <= 1'b0;
      ovf_q    <= 1'b0;
      und_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      dig_q    <= dig_d;
      strobe_q <= strobe_d;
      ovf_q    <= ovf_d;
      und_q    <= und_d;
    end
  end

  assign o_digital       = dig_q;
  assign o_sample_strobe = strobe_q;
  assign o_fifo_full     = fifo_full;
  assign o_fifo_empty    = fifo_empty;
  assign o_overflow      = ovf_q;
  assign o_underrun      = und_q;

endmodule

// File: doc/dac_stream_player.md
Name: dac_stream_player

Overview:
- Sample-playback stage that produces the 16-bit o_digital word driven into the analog macro by digital_top.
- Assembles little-endian byte pairs from the pad byte stream into 16-bit samples and buffers them in a small FIFO.
- Releases one sample per programmable rate tick.
- Flags overflow and underrun as sticky status bits.

Parameters:
- DEPTH, 8, FIFO depth in samples; power of two, minimum 2.
- DATA_W, 16, sample width; fixed at 16 in this design.
- MIDSCALE, 16'h8000, idle/underrun output code.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low; synchronous deassert handled upstream.
- i_byte  input  8  stream byte.
- i_byte_valid  input  1  i_byte qualifier; one byte per asserted cycle.
- i_sync  input  1  pulse: discard partial word, realign to low byte.
- i_enable  input  1  playback enable.
- i_rate_div  input  8  tick period minus one, in clk cycles.
- i_clear  input  1  pulse: clear sticky flags.
- o_digital  output  16  current DAC code.
- o_sample_strobe  output  1  one-cycle pulse when o_digital is loaded from the FIFO.
- o_fifo_full  output  1  FIFO count == DEPTH.
- o_fifo_empty  output  1  FIFO count == 0.
- o_overflow  output  1  sticky: a word was dropped because the FIFO was full.
- o_underrun  output  1  sticky: a tick found the FIFO empty.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n). Polarity and synchronicity are fixed.
- Reset values:
  - o_digital = MIDSCALE.
  - o_sample_strobe = 0, o_overflow = 0, o_underrun = 0.
  - FIFO empty, so o_fifo_empty = 1 and o_fifo_full = 0.
  - Assembler in LO_WAIT; rate counter = 0.
  - Reset mid-operation discards all buffered and partial data.
- Assembler FSM, states LO_WAIT and HI_WAIT:
  - LO_WAIT + valid: latch i_byte as low byte, go to HI_WAIT.
  - HI_WAIT + valid: form {i_byte, lo} and push; return to LO_WAIT.
  - If the FIFO is full at push and no pop occurs that cycle: drop the word and set o_overflow.
  - i_sync forces LO_WAIT. With i_sync and valid in the same cycle, the byte is taken as a new low byte and the state becomes HI_WAIT.
- Rate counter:
  - When i_enable = 0: counter held at 0, no ticks, o_digital holds its value.
  - When enabled: tick fires when counter >= i_rate_div, and the counter then returns to 0; otherwise the counter increments.
  - Tick period is i_rate_div+1 cycles; i_rate_div = 0 gives a tick every cycle.
  - A live change of i_rate_div takes effect immediately via the >= compare.
- Tick handling:
  - FIFO non-empty: pop the head; o_digital <= head at the end of the tick cycle; o_sample_strobe = 1 for the following cycle.
  - FIFO empty: set o_underrun, o_digital <= MIDSCALE, no strobe.
- Simultaneous push and pop:
  - When full: both succeed, count unchanged, no overflow.
  - When empty: push stored, pop sees empty and underrun is raised (no bypass path).
- Latency: a word pushed at edge N is visible to a tick in cycle N+1 and appears on o_digital at edge N+2.
- Sticky flags: i_clear clears both. If a set event and i_clear occur in the same cycle, set wins.
- Status outputs o_fifo_full and o_fifo_empty are registered-count derived, with no combinational path from inputs.

Optional Feature:
- Macro: DAC_PLAYER_HOLD_LAST_EN.
- Defined: on underrun, o_digital holds the last played sample instead of loading MIDSCALE. o_underrun is still set.
- Undefined: o_digital loads MIDSCALE on underrun, as specified above.

Decomposition:
- Package dac_player_pkg contains:
  - DATA_W and MIDSCALE constants.
  - Assembler state enum (LO_WAIT, HI_WAIT).
  - Rate-divider width constant (8).
- Sub-module sync_fifo (DEPTH, DATA_W):
  - Interface: push, pop, data in/out, full, empty, count.
  - Handles simultaneous push/pop on full.
- Assembler, rate counter and flags stay in dac_stream_player.

Test Plan:
- Reset release, no input -> o_digital = 16'h8000, o_fifo_empty = 1, all flags 0, strobe never pulses with i_enable = 0.
- Bytes 0x34, 0x12, then 0xCD, 0xAB; i_enable = 1, i_rate_div = 3 -> o_digital = 16'h1234 then 16'hABCD, strobes exactly 4 cycles apart, then o_underrun = 1 and o_digital = 16'h8000 (16'hABCD with DAC_PLAYER_HOLD_LAST_EN).
- Push 9 words with i_enable = 0 -> o_fifo_full after 8, o_overflow = 1; enable and play -> exactly the first 8 words emerge in order.
- Send byte 0x55, pulse i_sync, then bytes 0x78, 0x56 -> sample 16'h5678 played; 0x55 discarded.
- With FIFO full, push a ninth word on a tick cycle (i_rate_div = 0) -> no overflow, count stays 8. Assert i_clear coincident with a new underrun -> o_underrun stays 1.
- Assert rst_n low mid-playback with 5 words buffered -> outputs return immediately to reset values; no stale word plays after release.
